regfile_acc: RTL and testbench
==============================

# regfile_acc

Operand/writeback stage for the WF8 8-bit datapath. Holds the accumulator and general registers x0–x6 and drives the ALU `a` operand (accumulator or PC) and `b` operand (register or zero-extended 4-bit immediate). It captures the ALU result into a one-deep writeback register and commits it on the following cycle. Reads of a register with a pending write are forwarded from that writeback register.

## Interface
- `BIT_COUNT`, 8, datapath width
- `REG_COUNT`, 7, number of general registers (x0..x6); register index 7 encodes the accumulator or the immediate, depending on the port
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset; synchronous, active-high
- `op_valid`  in  1  decoder presents an operation this cycle
- `op_ready`  out  1  stage accepts the operation; equals `~hold & ~rst`
- `hold`  in  1  downstream stall request
- `a_sel`  in  1  0 = accumulator, 1 = `pc_in`
- `pc_in`  in  BIT_COUNT  program counter, for the `a` operand
- `b_sel`  in  3  0–6 = xN; 7 = immediate
- `imm_in`  in  4  immediate, zero-extended onto `b`
- `a_out`  out  BIT_COUNT  ALU operand a (combinational)
- `b_out`  out  BIT_COUNT  ALU operand b (combinational)
- `alu_c`  in  BIT_COUNT  ALU result for the current operation
- `wb_en`  in  1  the operation writes a result
- `wb_dest`  in  3  0–6 = xN; 7 = accumulator
- `acc_out`  out  BIT_COUNT  architectural accumulator, committed value, for debug
- `zflag`  out  1  zero flag; present only with `WF8_ZFLAG_EN`

## Operation
- **Fire:** `op_valid & op_ready`.
- **Operand read:**
  - `a_out` = `pc_in` if `a_sel`, else the accumulator.
  - `b_out` = `{4'b0, imm_in}` if `b_sel == 7`, else xN.
  - Both outputs are combinational.
- **Forwarding:** if `pend_valid` and `pend_dest` matches the read source, the operand is `pend_data` instead of the array value.
  - For `a`: `pend_dest == 7` and `a_sel == 0`.
  - For `b`: `pend_dest == b_sel` with `b_sel < 7`.
- **Capture:** on fire with `wb_en`, load `pend_valid <= 1`, `pend_dest <= wb_dest`, `pend_data <= alu_c`.
  - On fire with `!wb_en`, or on no fire, `pend_valid <= 0`.
- **Commit:** whenever `pend_valid` is 1, write `pend_data` into `pend_dest` (accumulator or xN) at the clock edge.
  - Commit is independent of `hold` and `op_valid`. A pending write is never lost or delayed by a stall.
- Commit and capture happen on the same edge for back-to-back operations. The array receives the older value while the pending register takes the newer one.
- `wb_dest` is 3 bits, so there is no illegal encoding. Arithmetic width is owned by the ALU; this stage only stores and forwards BIT_COUNT-bit values.
- `acc_out` shows the committed accumulator only; it is not forwarded.

## Timing
- **Reset values:** accumulator = 0, x0..x6 = 0, `pend_valid` = 0, `zflag` = 0.
  - With `a_sel = 0` and `b_sel = 0`, `a_out` and `b_out` read 0.
  - `op_ready` = 0 while `rst` is high.
- **Reset during operation:** the pending write is discarded, not committed. Any fire presented in the reset cycle is ignored.
- **Latency:**
  - Operands are valid in the same cycle as fire.
  - A result is visible through forwarding from cycle N+1.
  - The result is in the array, and on `acc_out`, from cycle N+2.
- **Stall:** `hold` high forces `op_ready` = 0. No new capture occurs; a pending write still commits on the next edge.
- Throughput is one operation per cycle while `hold` is low.

## Configuration
- **`WF8_ZFLAG_EN` defined:**
  - On each commit, `zflag <= (pend_data == 0)`.
  - Only commits to the accumulator update `zflag`; commits to xN leave it unchanged.
  - `zflag` is reset to 0.
- **`WF8_ZFLAG_EN` not defined:** the `zflag` port and its register do not exist; all other behaviour is identical.

## Test plan
- Reset, then idle:
  - `a_out = 0`, `b_out = 0`, `acc_out = 0`, `op_ready = 0` during `rst`.
  - `op_ready = 1` after `rst` falls with `hold = 0`.
- Fire with `b_sel = 7`, `imm_in = 4'hA`, `wb_en = 1`, `wb_dest = 7`, `alu_c = 8'h0A`:
  - `b_out = 8'h0A` in the fire cycle.
  - `acc_out = 8'h0A` two cycles later.
- Back-to-back forwarding:
  - Op1 writes x3 = `8'h55`.
  - The next cycle, op2 with `b_sel = 3` sees `b_out = 8'h55` before the commit.
  - The same applies to `a_sel = 0` after an accumulator write.
- Consecutive writes to the same destination:
  - x2 = `8'h11`, then x2 = `8'h22`. A read of x2 in the third cycle returns `8'h22` (forwarded); the array holds `8'h22` in the fourth cycle.
- Stall and reset:
  - Fire writes the accumulator = `8'h33`, then `hold = 1`. `op_ready = 0`, and `acc_out = 8'h33` still appears after the commit.
  - Repeat with `rst` asserted in the cycle after fire: `acc_out` stays 0.
- `WF8_ZFLAG_EN` only:
  - Accumulator write of `8'h00` gives `zflag = 1` after commit.
  - Then an x1 write of `8'h05` leaves `zflag = 1`.
  - Then an accumulator write of `8'h01` gives `zflag = 0`.

Source files
------------

// File: rtl/regfile_acc.sv
// regfile_acc: operand/writeback stage for the WF8 8-bit datapath.
// Holds the accumulator and x0..x6, muxes the ALU a/b operands and keeps a
// one-deep pending writeback that is forwarded to reads and committed on the
// following edge.
// Optional feature: define WF8_ZFLAG_EN to add the accumulator zero flag
// (port zflag); without it the port and its register do not exist.
module regfile_acc #(
  parameter int BIT_COUNT = 8,
  parameter int REG_COUNT = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic                 hold,
  input  logic                 a_sel,
  input  logic [BIT_COUNT-1:0] pc_in,
  input  logic [2:0]           b_sel,
  input  logic [3:0]           imm_in,
  output logic [BIT_COUNT-1:0] a_out,
  output logic [BIT_COUNT-1:0] b_out,
  input  logic [BIT_COUNT-1:0] alu_c,
  input  logic                 wb_en,
  input  logic [2:0]           wb_dest,
  output logic [BIT_COUNT-1:0] acc_out
`ifdef WF8_ZFLAG_EN
  ,
  output logic                 zflag
`endif
);

  // Architectural state
  logic [BIT_COUNT-1:0] r_acc;
  logic [BIT_COUNT-1:0] r_xreg [REG_COUNT];

  // One-deep writeback register
  logic                 r_pend_valid;
  logic [2:0]           r_pend_dest;
  logic [BIT_COUNT-1:0] r_pend_data;

  logic                 w_fire;
  logic                 w_capture;
  logic                 w_acc_commit;
  logic [REG_COUNT-1:0] w_x_commit;
  logic                 w_fwd_a;
  logic                 w_fwd_b;
  logic [BIT_COUNT-1:0] w_b_reg;

  // Reset gates readiness so an operation presented during reset is dropped.
  assign op_ready  = ~hold & ~rst;
  assign w_fire    = op_valid & op_ready;
  assign w_capture = w_fire & wb_en;

  // Destination index 7 is the accumulator; 0..6 select xN.
  assign w_acc_commit = r_pend_valid && (r_pend_dest == 3'd7);

  // Per-register commit strobes decoded from the pending destination.
  generate
    for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_commit_en
      assign w_x_commit[gi] = r_pend_valid && (r_pend_dest == 3'(gi));
    end
  endgenerate

  // Array read for the b operand (index 7 is never a register here).
  always_comb begin
    w_b_reg = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (b_sel == 3'(i)) begin
        w_b_reg = r_xreg[i];
      end
    end
  end

  // Operand muxes with forwarding from the pending writeback.
  always_comb begin
    w_fwd_a = r_pend_valid && (r_pend_dest == 3'd7) && !a_sel;
    w_fwd_b = r_pend_valid && (r_pend_dest == b_sel) && (b_sel != 3'd7);
    if (a_sel) begin
      a_out = pc_in;
    end else if (w_fwd_a) begin
      a_out = r_pend_data;
    end else begin
      a_out = r_acc;
    end
    if (b_sel == 3'd7) begin
      b_out = {{(BIT_COUNT-4){1'b0}}, imm_in};
    end else if (w_fwd_b) begin
      b_out = r_pend_data;
    end else begin
      b_out = w_b_reg;
    end
  end

  // Capture the ALU result on a writing fire; otherwise the slot empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_valid <= 1'b0;
      r_pend_dest  <= 3'd0;
      r_pend_data  <= '0;
    end else begin
      r_pend_valid <= w_capture;
      if (w_capture) begin
        r_pend_dest <= wb_dest;
        r_pend_data <= alu_c;
      end
    end
  end

  // Commit the pending value into the accumulator (independent of hold).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_acc_commit) begin
      r_acc <= r_pend_data;
    end
  end

  // Commit the pending value into the general register it targets.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_xreg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (w_x_commit[i]) begin
          r_xreg[i] <= r_pend_data;
        end
      end
    end
  end

  assign acc_out = r_acc;

`ifdef WF8_ZFLAG_EN
  logic r_zflag;

  // Zero flag tracks only accumulator commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_zflag <= 1'b0;
    end else if (w_acc_commit) begin
      r_zflag <= (r_pend_data == '0);
    end
  end

  assign zflag = r_zflag;
`endif

endmodule

// File: tb/tb_regfile_acc.sv
// tb_regfile_acc: directed stimulus with a cycle-tagged scoreboard; the
// stimulus pushes expectations, a negedge monitor pops and compares them.
module tb_regfile_acc;

  localparam int SIG_A   = 0;
  localparam int SIG_B   = 1;
  localparam int SIG_ACC = 2;
  localparam int SIG_RDY = 3;
  localparam int SIG_Z   = 4;

  typedef struct {
    int         cyc;
    int         sig;
    logic [7:0] val;
    string      name;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       op_valid;
  logic       op_ready;
  logic       hold;
  logic       a_sel;
  logic [7:0] pc_in;
  logic [2:0] b_sel;
  logic [3:0] imm_in;
  logic [7:0] a_out;
  logic [7:0] b_out;
  logic [7:0] alu_c;
  logic       wb_en;
  logic [2:0] wb_dest;
  logic [7:0] acc_out;
`ifdef WF8_ZFLAG_EN
  logic       zflag;
`endif

  int   cyc;
  int   total;
  int   bad;
  exp_t sb_q[$];

  regfile_acc #(.BIT_COUNT(8), .REG_COUNT(7)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .hold     (hold),
    .a_sel    (a_sel),
    .pc_in    (pc_in),
    .b_sel    (b_sel),
    .imm_in   (imm_in),
    .a_out    (a_out),
    .b_out    (b_out),
    .alu_c    (alu_c),
    .wb_en    (wb_en),
    .wb_dest  (wb_dest),
    .acc_out  (acc_out)
`ifdef WF8_ZFLAG_EN
    ,
    .zflag    (zflag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation tagged for the current cycle.
  always @(negedge clk) begin
    logic [7:0] act;
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc == cyc) begin
        case (sb_q[i].sig)
          SIG_A:   act = a_out;
          SIG_B:   act = b_out;
          SIG_ACC: act = acc_out;
          SIG_RDY: act = {7'd0, op_ready};
`ifdef WF8_ZFLAG_EN
          SIG_Z:   act = {7'd0, zflag};
`endif
          default: act = 8'hxx;
        endcase
        total++;
        if (act !== sb_q[i].val) begin
          bad++;
          $display("FAIL %s cyc=%0d actual=%h expected=%h",
                   sb_q[i].name, cyc, act, sb_q[i].val);
        end else begin
          $display("ok   %s cyc=%0d value=%h", sb_q[i].name, cyc, act);
        end
        sb_q.delete(i);
      end
    end
  end

  task automatic expect_at(input int dc, input int sig, input logic [7:0] v,
                           input string nm);
    exp_t e;
    e.cyc  = cyc + dc;
    e.sig  = sig;
    e.val  = v;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic asel, input logic [2:0] bsel,
                       input logic [3:0] imm, input logic we,
                       input logic [2:0] dest, input logic [7:0] c);
    op_valid = v;
    a_sel    = asel;
    b_sel    = bsel;
    imm_in   = imm;
    wb_en    = we;
    wb_dest  = dest;
    alu_c    = c;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    hold     = 1'b0;
    pc_in    = 8'h00;
    drive(1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 8'h00);

    // Reset state
    step();
    expect_at(0, SIG_A,   8'h00, "rst_a_out");
    expect_at(0, SIG_B,   8'h00, "rst_b_out");
    expect_at(0, SIG_ACC, 8'h00, "rst_acc_out");
    expect_at(0, SIG_RDY, 8'h00, "rst_op_ready");
`ifdef WF8_ZFLAG_EN
    expect_at(0, SIG_Z,   8'h00, "rst_zflag");
`endif
    step();
    rst = 1'b0;
    expect_at(0, SIG_RDY, 8'h01, "idle_op_ready");

    // Immediate operand, accumulator write of 0x0A
    step();
    drive(1'b1, 1'b0, 3'd7, 4'hA, 1'b1, 3'd7, 8'h0A);
    expect_at(0, SIG_B,   8'h0A, "imm_b_out");
    expect_at(1, SIG_ACC, 8'h00, "imm_acc_not_yet");
    expect_at(1, SIG_A,   8'h0A, "imm_a_fwd");
    expect_at(2, SIG_ACC, 8'h0A, "imm_acc_commit");
    step();
    drive(1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 8'h00);
    step();

    // Back-to-back: x3 = 55, then read x3 and write acc = 77
    step();
    drive(1'b1, 1'b0, 3'd0, 4'h0, 1'b1, 3'd3, 8'h55);
    expect_at(0, SIG_A, 8'h0A, "b2b_a_acc");
    step();
    drive(1'b1, 1'b0, 3'd3, 4'h0, 1'b1, 3'd7, 8'h77);
    expect_at(0, SIG_B, 8'h55, "b2b_b_fwd_x3");
    step();
    drive(1'b1, 1'b0, 3'd3, 4'h0, 1'b0, 3'd0, 8'h00);
    expect_at(0, SIG_A,   8'h77, "b2b_a_fwd_acc");
    expect_at(0, SIG_B,   8'h55, "b2b_b_array_x3");
    expect_at(0, SIG_ACC, 8'h0A, "b2b_acc_old");
    expect_at(1, SIG_ACC, 8'h77, "b2b_acc_commit");

    // pc_in on the a operand
    step();
    pc_in = 8'hC3;
    drive(1'b1, 1'b1, 3'd7, 4'h5, 1'b0, 3'd0, 8'h00);
    expect_at(0, SIG_A, 8'hC3, "pc_a_out");
    expect_at(0, SIG_B, 8'h05, "pc_b_imm");

    // Consecutive writes to x2
    step();
    drive(1'b1, 1'b0, 3'd2, 4'h0, 1'b1, 3'd2, 8'h11);
    expect_at(0, SIG_B, 8'h00, "x2_b_before");
    step();
    drive(1'b1, 1'b0, 3'd2, 4'h0, 1'b1, 3'd2, 8'h22);
    expect_at(0, SIG_B, 8'h11, "x2_b_fwd_first");
    step();
    drive(1'b1, 1'b0, 3'd2, 4'h0, 1'b0, 3'd0, 8'h00);
    expect_at(0, SIG_B, 8'h22, "x2_b_fwd_second");
    step();
    drive(1'b0, 1'b0, 3'd2, 4'h0, 1'b0, 3'd0, 8'h00);
    expect_at(0, SIG_B, 8'h22, "x2_b_array");

    // Stall: acc = 33 then hold; a held write request must not capture
    step();
    drive(1'b1, 1'b0, 3'd0, 4'h0, 1'b1, 3'd7, 8'h33);
    step();
    hold = 1'b1;
    drive(1'b1, 1'b0, 3'd0, 4'h0, 1'b1, 3'd7, 8'hEE);
    expect_at(0, SIG_RDY, 8'h00, "stall_op_ready");
    expect_at(0, SIG_A,   8'h33, "stall_a_fwd");
    expect_at(1, SIG_ACC, 8'h33, "stall_acc_commit");
    expect_at(1, SIG_A,   8'h33, "stall_a_array");
    step();
    step();
    hold = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 8'h00);
    expect_at(0, SIG_ACC, 8'h33, "stall_no_capture");

    // Reset in the cycle after fire: pending write discarded
    step();
    drive(1'b1, 1'b0, 3'd0, 4'h0, 1'b1, 3'd7, 8'h44);
    step();
    rst = 1'b1;
    drive(1'b1, 1'b0, 3'd0, 4'h0, 1'b1, 3'd7, 8'h99);
    expect_at(0, SIG_RDY, 8'h00, "rstop_op_ready");
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 3'd3, 4'h0, 1'b0, 3'd0, 8'h00);
    expect_at(0, SIG_ACC, 8'h00, "rstop_acc");
    expect_at(0, SIG_A,   8'h00, "rstop_a_no_fwd");
    expect_at(0, SIG_B,   8'h00, "rstop_x3_cleared");
    expect_at(1, SIG_ACC, 8'h00, "rstop_acc_later");

`ifdef WF8_ZFLAG_EN
    // Zero flag follows accumulator commits only
    step();
    drive(1'b1, 1'b0, 3'd0, 4'h0, 1'b1, 3'd7, 8'h00);
    expect_at(1, SIG_Z, 8'h00, "z_before_commit");
    expect_at(2, SIG_Z, 8'h01, "z_acc_zero");
    step();
    drive(1'b1, 1'b0, 3'd0, 4'h0, 1'b1, 3'd1, 8'h05);
    expect_at(2, SIG_Z, 8'h01, "z_xreg_no_change");
    step();
    drive(1'b1, 1'b0, 3'd0, 4'h0, 1'b1, 3'd7, 8'h01);
    expect_at(2, SIG_Z, 8'h00, "z_acc_nonzero");
`endif

    step();
    drive(1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 8'h00);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
      step();
    end
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
